// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, ctrl command
// encodings, default frame geometry and the counter-width helper.
package spi_pkg;

    localparam int DEF_FRAME_WIDTH = 8;
    localparam int DEF_CTRL_WIDTH  = 2;
    localparam int DEF_RD_WAIT     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT_RD,
        ST_CAPTURE,
        ST_RELEASE
    } state_e;

    typedef logic [1:0] ctrl_t;

    localparam ctrl_t WR_ADDR = 2'b00;
    localparam ctrl_t WR_DATA = 2'b01;
    localparam ctrl_t RD_ADDR = 2'b10;
    localparam ctrl_t RD_DATA = 2'b11;

    // The shared bit counter also times WAIT_RD and CAPTURE, so it must hold
    // the largest of the three phase lengths; at the defaults this is 4 bits.
    function automatic int cntWidth(int shiftBits, int rdWait, int frameBits);
        int maxLen;
        maxLen = shiftBits;
        if (rdWait > maxLen) maxLen = rdWait;
        if (frameBits > maxLen) maxLen = frameBits;
        return $clog2(maxLen + 1);
    endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master: sends a {ctrl, data} frame MSB first and, for read-data
// commands, captures a FRAME_WIDTH-bit reply RD_WAIT cycles later.
module spi_master
    import spi_pkg::*;
#(
    parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
    parameter int CTRL_WIDTH  = DEF_CTRL_WIDTH,
    parameter int RD_WAIT     = DEF_RD_WAIT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [CTRL_WIDTH+FRAME_WIDTH-1:0] cmd_data,
    output logic                             busy,
    output logic                             done,
    output logic                             rd_valid,
    output logic [FRAME_WIDTH-1:0]           rd_data,
    output logic                             SS_n,
    output logic                             MOSI,
    input  logic                             MISO
);

    localparam int TOTAL_BITS = CTRL_WIDTH + FRAME_WIDTH;
    localparam int CNT_W      = cntWidth(TOTAL_BITS, RD_WAIT, FRAME_WIDTH);

    state_e                  state_q, state_d;
    logic [TOTAL_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    isRead_q, isRead_d;
    logic                    ssn_q, ssn_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rdValid_q, rdValid_d;
    logic [FRAME_WIDTH-1:0]  rdData_q, rdData_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            isRead_q  <= 1'b0;
            ssn_q     <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            isRead_q  <= isRead_d;
            ssn_q     <= ssn_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdValid_q <= rdValid_d;
            rdData_q  <= rdData_d;
        end
    end

    // Outputs are registered from the next state, so each output register
    // already shows the value belonging to the state being entered.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        isRead_d  = isRead_q;
        mosi_d    = 1'b0;
        rdData_d  = rdData_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SELECT;
                    shreg_d  = cmd_data;
                    cnt_d    = '0;
                    isRead_d = (cmd_data[TOTAL_BITS-1 -: CTRL_WIDTH] == CTRL_WIDTH'(RD_DATA));
                end
            end
            ST_SELECT: begin
                state_d = ST_CMD;
                mosi_d  = shreg_q[TOTAL_BITS-1];
            end
            ST_CMD: begin
                state_d = ST_SHIFT;
                mosi_d  = shreg_q[TOTAL_BITS-1];
                shreg_d = shreg_q << 1;
                cnt_d   = CNT_W'(1);
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(TOTAL_BITS)) begin
                    state_d = isRead_q ? ST_WAIT_RD : ST_RELEASE;
                    cnt_d   = isRead_q ? CNT_W'(1) : '0;
                end else begin
                    mosi_d  = shreg_q[TOTAL_BITS-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RD: begin
                if (cnt_q == CNT_W'(RD_WAIT)) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                shreg_d = {shreg_q[TOTAL_BITS-2:0], MISO};
                if (cnt_q == CNT_W'(FRAME_WIDTH)) begin
                    state_d  = ST_RELEASE;
                    cnt_d    = '0;
                    rdData_d = {shreg_q[FRAME_WIDTH-2:0], MISO};
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ssn_d     = !(state_d inside {ST_SELECT, ST_CMD, ST_SHIFT, ST_WAIT_RD, ST_CAPTURE});
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_RELEASE);
        rdValid_d = (state_d == ST_RELEASE) && isRead_q;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rdValid_q;
    assign rd_data  = rdData_q;
    assign SS_n     = ssn_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a RAM-backed slave on the link, a
// command-level scoreboard, a vector table, random frames and corner cases.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] cmd_data = '0;
   logic       MISO = 1'b0;
   logic       busy, done, rd_valid, SS_n, MOSI;
   logic [7:0] rd_data;

   spi_master dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_data(cmd_data),
      .busy(busy), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Link monitor and slave state (written only by the monitor process)
   bit         mosiQ[$];
   int         lowLen = 0;
   int         highLen = 0;
   int         lastLowLen = 0;
   int         framesEnded = 0;
   int         gaps[$];
   int         lowLens[$];
   int         doneCnt = 0;
   int         rvCnt = 0;
   int         rvNoDone = 0;
   logic       prevSsn = 1'b1;
   logic [7:0] slaveRam[256] = '{default: 8'h00};
   bit         slaveWritten[256] = '{default: 1'b0};
   logic [7:0] slaveAddr = 8'h00;

   // Command-level reference model (written only by the test process)
   logic [7:0] modelRam[256];
   logic [7:0] modelAddr = 8'h00;
   logic [7:0] modelRd = 8'h00;

   typedef struct {
      logic [9:0] cmd;
      int         expLowLen;
      bit         expRv;
      logic [7:0] expRd;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [7:0] defaultByte(input logic [7:0] a);
      return (a == 8'hC3) ? 8'h5A : (a ^ 8'h96);
   endfunction

   function automatic logic [7:0] slaveByte(input logic [7:0] a);
      return slaveWritten[a] ? slaveRam[a] : defaultByte(a);
   endfunction

   // Expected MOSI over the SS_n-low window: an idle bit, the command bit,
   // the whole frame MSB first, then zeros for the rest of the window.
   function automatic logic [31:0] expMosi(input logic [9:0] cmd, input int len);
      bit q[$];
      logic [31:0] p = '0;
      q.push_back(1'b0);
      q.push_back(cmd[9]);
      for (int i = 9; i >= 0; i--) q.push_back(cmd[i]);
      while (q.size() < len) q.push_back(1'b0);
      foreach (q[i]) p = {p[30:0], q[i]};
      return p;
   endfunction

   // Monitor the link on the falling edge and play the slave's part
   always @(negedge clk) begin : monitor
      int idx;
      logic [1:0] ctrl;
      logic [7:0] data;
      if (SS_n === 1'b0) begin
         if (prevSsn) begin
            if (framesEnded > 0) gaps.push_back(highLen);
            mosiQ.delete();
            lowLen = 0;
         end
         idx = lowLen;
         mosiQ.push_back(MOSI);
         lowLen++;
         if (idx >= 14 && idx < 22 && mosiQ[2] && mosiQ[3])
            MISO = slaveByte(slaveAddr)[21 - idx];
         else
            MISO = 1'($urandom);
         prevSsn = 1'b0;
      end else begin
         MISO = 1'($urandom);
         if (prevSsn == 1'b0) begin
            lastLowLen = lowLen;
            lowLens.push_back(lowLen);
            framesEnded++;
            highLen = 0;
            if (lowLen >= 12) begin
               ctrl = {mosiQ[2], mosiQ[3]};
               data = '0;
               for (int j = 0; j < 8; j++) data = {data[6:0], mosiQ[4 + j]};
               if (ctrl == 2'b01) begin
                  slaveRam[slaveAddr] = data;
                  slaveWritten[slaveAddr] = 1'b1;
               end else if (ctrl != 2'b11) begin
                  slaveAddr = data;
               end
            end
         end
         highLen++;
         prevSsn = 1'b1;
      end
      if (done === 1'b1) doneCnt++;
      if (rd_valid === 1'b1) rvCnt++;
      if (rd_valid === 1'b1 && done !== 1'b1) rvNoDone++;
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard update from the command alone
   task automatic modelFrame(input logic [9:0] cmd, output int expLen, output bit expRv, output logic [7:0] expRd);
      logic [1:0] ctrl = cmd[9:8];
      logic [7:0] data = cmd[7:0];
      expRv = 1'b0;
      expLen = 12;
      if (ctrl == 2'b11) begin
         modelRd = modelRam[modelAddr];
         expRv = 1'b1;
         expLen = 22;
      end else if (ctrl == 2'b01) begin
         modelRam[modelAddr] = data;
      end else begin
         modelAddr = data;
      end
      expRd = modelRd;
   endtask

   // Issue one frame and wait (bounded) for its done pulse
   task automatic applyStimulus(input logic [9:0] cmd, output int dDone, output int dRv, output int dRvNoDone, output bit ok);
      int d0, r0, n0, t;
      @(posedge clk); #1;
      start = 1'b1;
      cmd_data = cmd;
      d0 = doneCnt; r0 = rvCnt; n0 = rvNoDone;
      @(posedge clk); #1;
      start = 1'b0;
      cmd_data = 10'($urandom);
      t = 0;
      while (doneCnt == d0 && t < 60) begin
         @(negedge clk); #1;
         t++;
      end
      ok = (doneCnt != d0);
      dDone = doneCnt - d0;
      dRv = rvCnt - r0;
      dRvNoDone = rvNoDone - n0;
   endtask

   task automatic runFrame(input string tag, input logic [9:0] cmd, input int expLen, input bit expRv, input logic [7:0] expRd);
      int dDone, dRv, dNo;
      bit ok;
      logic [31:0] act = '0;
      applyStimulus(cmd, dDone, dRv, dNo, ok);
      if (!ok) checkOutput({tag, " doneTimeout"}, 32'd0, 32'd1);
      foreach (mosiQ[i]) act = {act[30:0], mosiQ[i]};
      checkOutput({tag, " ssLowLen"}, 32'(lastLowLen), 32'(expLen));
      checkOutput({tag, " mosi"}, act, expMosi(cmd, expLen));
      checkOutput({tag, " donePulses"}, 32'(dDone), 32'd1);
      checkOutput({tag, " rdValidPulses"}, 32'(dRv), 32'(expRv));
      checkOutput({tag, " rdValidWithoutDone"}, 32'(dNo), 32'd0);
      checkOutput({tag, " rdData"}, 32'(rd_data), 32'(expRd));
   endtask

   initial begin : test
      int expLen, d0, g0, l0, t;
      bit expRv;
      logic [7:0] expRd;
      logic [31:0] act;
      logic [9:0] rc;

      for (int i = 0; i < 256; i++) modelRam[i] = defaultByte(8'(i));

      vecs[0] = '{10'h0A5, 12, 1'b0, 8'h00};
      vecs[1] = '{10'h2C3, 12, 1'b0, 8'h00};
      vecs[2] = '{10'h300, 22, 1'b1, 8'h5A};
      vecs[3] = '{10'h010, 12, 1'b0, 8'h5A};
      vecs[4] = '{10'h1C3, 12, 1'b0, 8'h5A};
      vecs[5] = '{10'h210, 12, 1'b0, 8'h5A};
      vecs[6] = '{10'h300, 22, 1'b1, 8'hC3};
      vecs[7] = '{10'h3FF, 22, 1'b1, 8'hC3};

      // Two-cycle reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetSsn", 32'(SS_n), 32'd1);
      checkOutput("resetMosi", 32'(MOSI), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetRdValid", 32'(rd_valid), 32'd0);
      checkOutput("resetRdData", 32'(rd_data), 32'd0);
      rst_n = 1'b1;

      // Directed table, including the RAM loop-back sequence
      foreach (vecs[i]) begin
         modelFrame(vecs[i].cmd, expLen, expRv, expRd);
         runFrame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].expLowLen, vecs[i].expRv, vecs[i].expRd);
         if (i == 0) begin
            act = '0;
            foreach (mosiQ[k]) act = {act[30:0], mosiQ[k]};
            checkOutput("writeAddrMosiPattern", act, 32'h0A5);
         end
      end

      // Random frames against the command-level model
      for (int i = 0; i < 16; i++) begin
         rc = 10'($urandom_range(0, 1023));
         modelFrame(rc, expLen, expRv, expRd);
         runFrame($sformatf("rand%0d", i), rc, expLen, expRv, expRd);
      end

      // start held for 30 cycles: a frame takes 14 cycles from acceptance to
      // the next acceptance (SELECT, CMD, 10 SHIFT, RELEASE, IDLE), so the
      // accepts land on edges 1, 15 and 29. Between frames SS_n is high for
      // RELEASE plus the one IDLE cycle.
      g0 = gaps.size();
      l0 = lowLens.size();
      d0 = doneCnt;
      @(posedge clk); #1;
      start = 1'b1;
      cmd_data = 10'h0A5;
      repeat (30) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) modelFrame(10'h0A5, expLen, expRv, expRd);
      checkOutput("heldFrames", 32'(lowLens.size() - l0), 32'd3);
      checkOutput("heldDonePulses", 32'(doneCnt - d0), 32'd3);
      checkOutput("heldGapCount", 32'(gaps.size() - g0), 32'd3);
      for (int i = g0 + 1; i < gaps.size(); i++) checkOutput($sformatf("heldGap%0d", i - g0), 32'(gaps[i]), 32'd2);
      for (int i = l0; i < lowLens.size(); i++) checkOutput($sformatf("heldLowLen%0d", i - l0), 32'(lowLens[i]), 32'd12);
      checkOutput("heldBusyAfter", 32'(busy), 32'd0);

      // Reset dropped while SHIFT is presenting frame bit 5
      @(posedge clk); #1;
      start = 1'b1;
      cmd_data = 10'h0A5;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (!(SS_n === 1'b0 && lowLen == 8) && t < 40) begin
         @(negedge clk); #1;
         t++;
      end
      if (t >= 40) checkOutput("abortReachBit5", 32'd0, 32'd1);
      d0 = doneCnt;
      rst_n = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      checkOutput("abortSsn", 32'(SS_n), 32'd1);
      checkOutput("abortMosi", 32'(MOSI), 32'd0);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortRdData", 32'(rd_data), 32'd0);
      repeat (30) @(negedge clk);
      #1;
      checkOutput("abortNoDone", 32'(doneCnt - d0), 32'd0);
      modelRd = 8'h00;

      // Normal traffic after the abort
      modelFrame(10'h0A5, expLen, expRv, expRd);
      runFrame("postAbortWr", 10'h0A5, expLen, expRv, expRd);
      modelFrame(10'h300, expLen, expRv, expRd);
      runFrame("postAbortRd", 10'h300, expLen, expRv, expRd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
